// File: rtl/ptp_round_scheduler.sv
// rtl/ptp_round_scheduler.sv - shared-medium piezo ping/listen round sequencer
//
// Walks the channels set in chan_mask in ascending order. For each channel it
// runs one exchange: a ping burst, then a listen window with self-ring
// blanking and a timeout, then a guard ring-down interval.
//
// Ports:
//   clock          system clock
//   reset          synchronous active-high reset
//   enable         level; low aborts activity and blocks start
//   start          single-cycle round request
//   chan_mask      channels to service, sampled on the accepted start
//   piezo_out      one-hot (or zero) ping drive
//   piezo_in       per-channel receive comparator (already synchronised)
//   busy           high from the cycle after an accepted start until idle
//   result_valid   one-cycle pulse per serviced channel
//   result_chan    channel of the current result
//   result_time    cycles from first ping cycle to detection, all-ones on timeout
//   result_timeout qualifies result_valid: 1 = no response
//   round_done     one-cycle pulse after the last channel's guard
module ptp_round_scheduler #(
   parameter int N_CH     = 4,
   parameter int PING_LEN = 5000,
   parameter int BLANK    = 7000,
   parameter int TIMEOUT  = 2000000,
   parameter int GUARD    = 2000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    start,
   input  logic [N_CH-1:0]         chan_mask,
   output logic [N_CH-1:0]         piezo_out,
   input  logic [N_CH-1:0]         piezo_in,
   output logic                    busy,
   output logic                    result_valid,
   output logic [$clog2(N_CH)-1:0] result_chan,
   output logic [31:0]             result_time,
   output logic                    result_timeout,
   output logic                    round_done
);

   localparam int CH_W = $clog2(N_CH);

   localparam logic [31:0] PING_LAST  = 32'(PING_LEN - 1);
   localparam logic [31:0] BLANK_C    = 32'(BLANK);
   localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);
   localparam logic [31:0] GUARD_LAST = 32'(GUARD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PING,
      S_LISTEN,
      S_GUARD
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [N_CH-1:0]   pend_q, pend_d;     // channels still to service this round
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [N_CH-1:0]   rem;                // pending channels after the current one

   logic [N_CH-1:0]   piezo_out_d;
   logic              busy_d;
   logic              result_valid_d;
   logic [CH_W-1:0]   result_chan_d;
   logic [31:0]       result_time_d;
   logic              result_timeout_d;
   logic              round_done_d;

   function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] v);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (v[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
      logic [N_CH-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      pend_d           = pend_q;
      ch_d             = ch_q;
      piezo_out_d      = piezo_out;
      busy_d           = busy;
      result_valid_d   = 1'b0;
      result_chan_d    = result_chan;
      result_time_d    = result_time;
      result_timeout_d = result_timeout;
      round_done_d     = 1'b0;
      rem              = pend_q & ~ch_onehot(ch_q);

      case (state_q)
         S_IDLE: begin
            if (start && (chan_mask != '0)) begin
               pend_d      = chan_mask;
               ch_d        = lowest_set(chan_mask);
               state_d     = S_PING;
               cnt_d       = '0;
               piezo_out_d = ch_onehot(lowest_set(chan_mask));
               busy_d      = 1'b1;
            end
         end

         S_PING: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == PING_LAST) begin
               state_d     = S_LISTEN;
               piezo_out_d = '0;
            end
         end

         S_LISTEN: begin
            // Detection is tested first so it wins over a same-cycle timeout.
            if (piezo_in[ch_q] && (cnt_q >= BLANK_C)) begin
               result_valid_d   = 1'b1;
               result_chan_d    = ch_q;
               result_time_d    = cnt_q;
               result_timeout_d = 1'b0;
               state_d          = S_GUARD;
               cnt_d            = '0;
            end else if (cnt_q == TO_LAST) begin
               result_valid_d   = 1'b1;
               result_chan_d    = ch_q;
               result_time_d    = 32'hFFFF_FFFF;
               result_timeout_d = 1'b1;
               state_d          = S_GUARD;
               cnt_d            = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         S_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               cnt_d = '0;
               if (rem != '0) begin
                  pend_d      = rem;
                  ch_d        = lowest_set(rem);
                  state_d     = S_PING;
                  piezo_out_d = ch_onehot(lowest_set(rem));
               end else begin
                  pend_d       = '0;
                  state_d      = S_IDLE;
                  busy_d       = 1'b0;
                  round_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort: the in-flight exchange produces nothing; earlier results stay.
      if (!enable) begin
         state_d          = S_IDLE;
         cnt_d            = '0;
         piezo_out_d      = '0;
         busy_d           = 1'b0;
         result_valid_d   = 1'b0;
         result_chan_d    = result_chan;
         result_time_d    = result_time;
         result_timeout_d = result_timeout;
         round_done_d     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         pend_q         <= '0;
         ch_q           <= '0;
         piezo_out      <= '0;
         busy           <= 1'b0;
         result_valid   <= 1'b0;
         result_chan    <= '0;
         result_time    <= '0;
         result_timeout <= 1'b0;
         round_done     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pend_q         <= pend_d;
         ch_q           <= ch_d;
         piezo_out      <= piezo_out_d;
         busy           <= busy_d;
         result_valid   <= result_valid_d;
         result_chan    <= result_chan_d;
         result_time    <= result_time_d;
         result_timeout <= result_timeout_d;
         round_done     <= round_done_d;
      end
   end

endmodule

// File: tb/tb_ptp_round_scheduler.sv
// tb/tb_ptp_round_scheduler.sv - directed table-driven bench for ptp_round_scheduler
module tb_ptp_round_scheduler;

   localparam int N_CH     = 4;
   localparam int PING_LEN = 10;
   localparam int BLANK    = 20;
   localparam int TIMEOUT  = 100;
   localparam int GUARD    = 5;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        start;
   logic [3:0]  chan_mask;
   logic [3:0]  piezo_out;
   logic [3:0]  piezo_in;
   logic        busy;
   logic        result_valid;
   logic [1:0]  result_chan;
   logic [31:0] result_time;
   logic        result_timeout;
   logic        round_done;

   int n_cmp = 0;
   int n_bad = 0;

   ptp_round_scheduler #(
      .N_CH     (N_CH),
      .PING_LEN (PING_LEN),
      .BLANK    (BLANK),
      .TIMEOUT  (TIMEOUT),
      .GUARD    (GUARD)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .start          (start),
      .chan_mask      (chan_mask),
      .piezo_out      (piezo_out),
      .piezo_in       (piezo_in),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_chan    (result_chan),
      .result_time    (result_time),
      .result_timeout (result_timeout),
      .round_done     (round_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]        mask;
      logic [3:0][7:0]   resp;      // response rise at this cnt, 8'hFF = never
      bit                preblank;  // selected channel high at cnt 0..15
      bit                noise;     // other channels toggle randomly
      logic [3:0][31:0]  exp_time;
      logic [3:0]        exp_to;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one round; interval k is the cycle after the k-th clock edge
   // counted from the edge that accepts start (k=0 is the first ping cycle).
   task automatic run_round(input vec_t v, input int restart_k, input string tag);
      int chs[4];
      int base[4];
      int rlen[4];
      int n;
      int b;
      int end_k;
      n = 0;
      b = 0;
      for (int c = 0; c < 4; c++) begin
         if (v.mask[c]) begin
            chs[n]  = c;
            base[n] = b;
            rlen[n] = v.exp_to[c] ? TIMEOUT - 1 : int'(v.exp_time[c]);
            b       = b + rlen[n] + 1 + GUARD;
            n++;
         end
      end
      end_k = b;

      @(negedge clock);
      start     = 1'b1;
      chan_mask = v.mask;
      @(negedge clock);
      start     = 1'b0;
      chan_mask = 4'($urandom);

      for (int k = 0; k <= end_k + 2; k++) begin
         logic [3:0]  exp_po;
         logic        exp_rv;
         logic [1:0]  exp_rc;
         logic [31:0] exp_rt;
         logic        exp_rto;
         logic [3:0]  pin;
         int          jc;
         int          l;
         exp_po  = '0;
         exp_rv  = 1'b0;
         exp_rc  = '0;
         exp_rt  = '0;
         exp_rto = 1'b0;
         jc      = -1;
         l       = 0;
         for (int j = 0; j < n; j++) begin
            if (k >= base[j] && k < base[j] + rlen[j] + 1 + GUARD) begin
               jc = j;
               l  = k - base[j];
               if (l < PING_LEN) exp_po[chs[j]] = 1'b1;
               if (l == rlen[j] + 1) begin
                  exp_rv  = 1'b1;
                  exp_rc  = 2'(chs[j]);
                  exp_rt  = v.exp_time[chs[j]];
                  exp_rto = v.exp_to[chs[j]];
               end
            end
         end
         check($sformatf("%s piezo_out k=%0d", tag, k), 32'(piezo_out), 32'(exp_po));
         check($sformatf("%s result_valid k=%0d", tag, k), 32'(result_valid), 32'(exp_rv));
         check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(k < end_k));
         check($sformatf("%s round_done k=%0d", tag, k), 32'(round_done), 32'(k == end_k));
         if (exp_rv) begin
            check($sformatf("%s result_chan k=%0d", tag, k), 32'(result_chan), 32'(exp_rc));
            check($sformatf("%s result_time k=%0d", tag, k), result_time, exp_rt);
            check($sformatf("%s result_timeout k=%0d", tag, k), 32'(result_timeout), 32'(exp_rto));
         end

         pin = v.noise ? 4'($urandom) : 4'b0000;
         if (jc >= 0) begin
            int c;
            c = chs[jc];
            pin[c] = (l <= rlen[jc]) &&
                     (((v.resp[c] != 8'hFF) && (l >= int'(v.resp[c]))) ||
                      (v.preblank && l <= 15));
         end
         piezo_in = pin;
         if (k == restart_k) begin
            start     = 1'b1;
            chan_mask = 4'b1110;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
      end
      start    = 1'b0;
      piezo_in = '0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " piezo_out"}, 32'(piezo_out), 32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
      check({tag, " result_valid"}, 32'(result_valid), 32'h0);
      check({tag, " round_done"}, 32'(round_done), 32'h0);
   endtask

   initial begin
      vecs[0].mask = 4'b0101; vecs[0].resp = {8'hFF, 8'd50, 8'hFF, 8'd37};
      vecs[0].preblank = 0; vecs[0].noise = 0;
      vecs[0].exp_time = {32'd0, 32'd50, 32'd0, 32'd37}; vecs[0].exp_to = 4'b0000;

      vecs[1].mask = 4'b0010; vecs[1].resp = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[1].preblank = 1; vecs[1].noise = 0;
      vecs[1].exp_time = {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0}; vecs[1].exp_to = 4'b0010;

      vecs[2].mask = 4'b1000; vecs[2].resp = {8'd99, 8'hFF, 8'hFF, 8'hFF};
      vecs[2].preblank = 0; vecs[2].noise = 0;
      vecs[2].exp_time = {32'd99, 32'd0, 32'd0, 32'd0}; vecs[2].exp_to = 4'b0000;

      vecs[3].mask = 4'b0001; vecs[3].resp = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[3].preblank = 0; vecs[3].noise = 1;
      vecs[3].exp_time = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}; vecs[3].exp_to = 4'b0001;

      vecs[4].mask = 4'b1111; vecs[4].resp = {8'd25, 8'd60, 8'd21, 8'd20};
      vecs[4].preblank = 0; vecs[4].noise = 0;
      vecs[4].exp_time = {32'd25, 32'd60, 32'd21, 32'd20}; vecs[4].exp_to = 4'b0000;

      reset     = 1'b1;
      enable    = 1'b1;
      start     = 1'b0;
      chan_mask = '0;
      piezo_in  = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check_idle("reset");
      check("reset result_chan", 32'(result_chan), 32'h0);
      check("reset result_time", result_time, 32'h0);
      check("reset result_timeout", 32'(result_timeout), 32'h0);

      for (int i = 0; i < 5; i++) begin
         run_round(vecs[i], -1, $sformatf("vec%0d", i));
      end

      // Abort by enable=0 during ping cnt=5 of channel 0.
      @(negedge clock);
      start     = 1'b1;
      chan_mask = 4'b0011;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("abort piezo_out k=%0d", k), 32'(piezo_out), 32'h1);
         check($sformatf("abort busy k=%0d", k), 32'(busy), 32'h1);
         if (k == 5) enable = 1'b0;
         @(negedge clock);
      end
      for (int k = 0; k < 150; k++) begin
         check_idle($sformatf("abort after k=%0d", k));
         if (k == 10) enable = 1'b1;
         @(negedge clock);
      end
      check("abort kept result_chan", 32'(result_chan), 32'h3);
      check("abort kept result_time", result_time, 32'd25);
      check("abort kept result_timeout", 32'(result_timeout), 32'h0);

      // Start while busy is ignored: only the chan0 timeout appears.
      run_round(vecs[3], 3, "restart");
      for (int k = 0; k < 20; k++) begin
         check_idle($sformatf("restart idle k=%0d", k));
         @(negedge clock);
      end

      // Start with an empty mask.
      @(negedge clock);
      start     = 1'b1;
      chan_mask = 4'b0000;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check_idle($sformatf("mask0 k=%0d", k));
         @(negedge clock);
      end

      // Synchronous reset while listening.
      @(negedge clock);
      start     = 1'b1;
      chan_mask = 4'b0100;
      @(negedge clock);
      start = 1'b0;
      repeat (30) @(negedge clock);
      check("pre-reset busy", 32'(busy), 32'h1);
      check("pre-reset result_chan", 32'(result_chan), 32'h0);
      check("pre-reset result_time", result_time, 32'hFFFF_FFFF);
      reset = 1'b1;
      @(negedge clock);
      check_idle("listen reset");
      check("listen reset result_chan", 32'(result_chan), 32'h0);
      check("listen reset result_time", result_time, 32'h0);
      check("listen reset result_timeout", 32'(result_timeout), 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 120; k++) begin
         check_idle($sformatf("post reset k=%0d", k));
         @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
